// File: rtl/snes_controller_reader.sv
// SNES pad poller: pulses latch, clocks out 16 serial bits and presents them as an active-high button word.
// Optional SNES_READER_DEBOUNCE_EN: buttons only change when two consecutive raw frames agree.
//
// state | meaning
// IDLE  | latch=0, clk=1, waiting for the poll counter to expire
// LATCH | latch=1 for LATCH_CYCLES, poll counter restarted on entry
// HIGH  | clk=1 half-period of the current bit
// LOW   | clk=0 half-period; bit index advances when it ends
// DONE  | one cycle, new frame published and valid pulsed
module snes_controller_reader #(
    parameter int LATCH_CYCLES = 25,
    parameter int HALF_CYCLES  = 12,
    parameter int POLL_CYCLES  = 34667
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [15:0] buttons,
    output logic        valid
);

    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);
    localparam logic [HW-1:0] HALF_LOAD  = HW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LOAD  = PW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [LW-1:0] lat_cnt;
    logic [HW-1:0] half_cnt;
    logic [PW-1:0] poll_cnt;
    logic [3:0]    bit_idx;
    logic [15:0]   shift;
    logic [15:0]   shift_d;
    logic [15:0]   raw_frame;
    logic          data_meta;
    logic          data_sync;
    logic          half_done;
    logic          latch_d;
    logic          clk_d;
    logic          valid_d;

    assign half_done = (half_cnt == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= snes_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (poll_cnt == '0) next_state = LATCH;
            LATCH: if (lat_cnt == '0) next_state = HIGH;
            HIGH:  if (half_done) next_state = LOW;
            LOW: begin
                if (half_done) begin
                    next_state = (bit_idx == 4'd15) ? DONE : HIGH;
                end
            end
            DONE:  next_state = (poll_cnt == '0) ? LATCH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pin values are registered from next_state so they line up exactly with the state.
    always_comb begin
        latch_d = (next_state == LATCH);
        clk_d   = (next_state != LOW);
        valid_d = (next_state == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snes_latch <= 1'b0;
            snes_clk   <= 1'b1;
            valid      <= 1'b0;
        end else begin
            snes_latch <= latch_d;
            snes_clk   <= clk_d;
            valid      <= valid_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt  <= LATCH_LOAD;
            half_cnt <= HALF_LOAD;
            poll_cnt <= '0;
        end else begin
            if (state != LATCH) begin
                lat_cnt <= LATCH_LOAD;
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (next_state != state) begin
                half_cnt <= HALF_LOAD;
            end else if (!half_done) begin
                half_cnt <= half_cnt - 1'b1;
            end

            if (next_state == LATCH && state != LATCH) begin
                poll_cnt <= POLL_LOAD;
            end else if (poll_cnt != '0) begin
                poll_cnt <= poll_cnt - 1'b1;
            end
        end
    end

    // The pad bit is taken as the clock rises again: the two-flop synchronizer
    // delay means data_sync then shows the pad output from late in the bit period.
    always_comb begin
        shift_d = shift;
        if (state == LATCH) begin
            shift_d = '0;
        end else if (state == LOW && half_done) begin
            shift_d[bit_idx] = data_sync;
        end
    end

    assign raw_frame = ~shift_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            shift <= shift_d;
            if (state == LATCH) begin
                bit_idx <= '0;
            end else if (state == LOW && half_done) begin
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

`ifdef SNES_READER_DEBOUNCE_EN
    logic [15:0] prev_raw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buttons  <= '0;
            prev_raw <= '0;
        end else if (next_state == DONE) begin
            if (raw_frame == prev_raw) begin
                buttons <= raw_frame;
            end
            prev_raw <= raw_frame;
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buttons <= '0;
        end else if (next_state == DONE) begin
            buttons <= raw_frame;
        end
    end
`endif

endmodule
